// File: rtl/clk_div_pkg.sv
// Shared types and arithmetic for the divider ramp controller: state encoding,
// divider-value normalisation and the clamped single-step rule.
package clk_div_pkg;

  // Helpers work on a fixed 32-bit container; callers size-cast in and out.
  localparam int unsigned CLK_DIV_FN_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DWELL = 2'd2
  } clk_div_ramp_state_e;

  // A divider value of 0 is meaningless; it is treated as divide-by-1.
  function automatic logic [CLK_DIV_FN_W-1:0] clk_div_norm(
    input logic [CLK_DIV_FN_W-1:0] v
  );
    return (v == '0) ? CLK_DIV_FN_W'(1) : v;
  endfunction

  // Move cur toward tgt by at most step, never overshooting; step 0 jumps.
  // The upward sum is one bit wider so it cannot wrap.
  function automatic logic [CLK_DIV_FN_W-1:0] clk_div_next_step(
    input logic [CLK_DIV_FN_W-1:0] cur,
    input logic [CLK_DIV_FN_W-1:0] tgt,
    input logic [CLK_DIV_FN_W-1:0] step
  );
    logic [CLK_DIV_FN_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (step == '0) return tgt;
    if (tgt > cur) return (sum > {1'b0, tgt}) ? tgt : sum[CLK_DIV_FN_W-1:0];
    if ((cur - tgt) <= step) return tgt;
    return cur - step;
  endfunction

endpackage

// File: rtl/clk_div_ramp_ctrl.sv
// Walks the integer clock divider toward a requested value in bounded steps,
// one div/valid/ready handshake per step with a programmable dwell in between.
module clk_div_ramp_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_VALUE_WIDTH   = 4,
  parameter int unsigned DEFAULT_DIV_VALUE = 1,
  parameter int unsigned DWELL_WIDTH       = 8,
  parameter int unsigned TIMEOUT_CYCLES    = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [DIV_VALUE_WIDTH-1:0] cfg_div_i,
  input  logic [DIV_VALUE_WIDTH-1:0] cfg_step_i,
  input  logic [DWELL_WIDTH-1:0]     cfg_dwell_i,
  input  logic                       cfg_valid_i,
  output logic                       cfg_ready_o,
  input  logic                       abort_i,
  output logic [DIV_VALUE_WIDTH-1:0] div_o,
  output logic                       div_valid_o,
  input  logic                       div_ready_i,
  output logic [DIV_VALUE_WIDTH-1:0] cur_div_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       timeout_o,
  input  logic                       clr_err_i
);

  localparam int unsigned W    = DIV_VALUE_WIDTH;
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0]    RESET_DIV = W'(clk_div_norm(32'(DEFAULT_DIV_VALUE)));
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

  clk_div_ramp_state_e state_q, state_d;
  logic [W-1:0]           div_q, div_d;
  logic [W-1:0]           cur_q, cur_d;
  logic [W-1:0]           tgt_q, tgt_d;
  logic [W-1:0]           step_q, step_d;
  logic [DWELL_WIDTH-1:0] dwell_q, dwell_d;
  logic [DWELL_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   done_q, done_d;
  logic                   to_set;
  logic [W-1:0]           cfg_tgt_norm;
  logic [W-1:0]           first_step;
  logic [W-1:0]           next_step;

  assign cfg_tgt_norm = W'(clk_div_norm(32'(cfg_div_i)));
  assign first_step   = W'(clk_div_next_step(32'(cur_q), 32'(cfg_tgt_norm), 32'(cfg_step_i)));
  assign next_step    = W'(clk_div_next_step(32'(cur_q), 32'(tgt_q), 32'(step_q)));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_d     = state_q;
    div_d       = div_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    dwell_d     = dwell_q;
    dwell_cnt_d = dwell_cnt_q;
    to_cnt_d    = to_cnt_q;
    done_d      = 1'b0;
    to_set      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          tgt_d   = cfg_tgt_norm;
          step_d  = cfg_step_i;
          dwell_d = cfg_dwell_i;
          if (cfg_tgt_norm == cur_q) begin
            done_d = 1'b1;
          end else begin
            div_d    = first_step;
            to_cnt_d = '0;
            state_d  = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        // abort and timeout never withdraw a pending request
        if (div_ready_i) begin
          cur_d = div_q;
          if (div_q == tgt_q) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else if (abort_i) begin
            state_d = ST_IDLE;
          end else begin
            dwell_cnt_d = dwell_q;
            state_d     = ST_DWELL;
          end
        end else if (to_cnt_q != TO_LIMIT) begin
          to_cnt_d = to_cnt_q + 1'b1;
          to_set   = (to_cnt_d == TO_LIMIT);
        end
      end

      ST_DWELL: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (dwell_cnt_q == '0) begin
          div_d    = next_step;
          to_cnt_d = '0;
          state_d  = ST_ISSUE;
        end else begin
          dwell_cnt_d = dwell_cnt_q - 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // set has priority over clear
    if (to_set)         timeout_d = 1'b1;
    else if (clr_err_i) timeout_d = 1'b0;
    else                timeout_d = timeout_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      div_q       <= RESET_DIV;
      cur_q       <= RESET_DIV;
      tgt_q       <= RESET_DIV;
      step_q      <= '0;
      dwell_q     <= '0;
      dwell_cnt_q <= '0;
      to_cnt_q    <= '0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      dwell_q     <= dwell_d;
      dwell_cnt_q <= dwell_cnt_d;
      to_cnt_q    <= to_cnt_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
    end
  end

  assign cfg_ready_o = (state_q == ST_IDLE);
  assign busy_o      = (state_q != ST_IDLE);
  assign div_valid_o = (state_q == ST_ISSUE);
  assign div_o       = div_q;
  assign cur_div_o   = cur_q;
  assign done_o      = done_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Directed bench for clk_div_ramp_ctrl: reset, same-value, ramp up/down,
// handshake timeout, abort in dwell and asynchronous reset during ISSUE.
module tb_clk_div_ramp_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [3:0] cfg_div_i = '0;
  logic [3:0] cfg_step_i = '0;
  logic [7:0] cfg_dwell_i = '0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_ready_o;
  logic       abort_i = 1'b0;
  logic [3:0] div_o;
  logic       div_valid_o;
  logic       div_ready_i = 1'b0;
  logic [3:0] cur_div_o;
  logic       busy_o;
  logic       done_o;
  logic       timeout_o;
  logic       clr_err_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int hs_val[$];
  int hs_cyc[$];
  int done_cyc[$];

  clk_div_ramp_ctrl #(
    .DIV_VALUE_WIDTH  (4),
    .DEFAULT_DIV_VALUE(0),
    .DWELL_WIDTH      (8),
    .TIMEOUT_CYCLES   (64)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_div_i  (cfg_div_i),
    .cfg_step_i (cfg_step_i),
    .cfg_dwell_i(cfg_dwell_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .abort_i    (abort_i),
    .div_o      (div_o),
    .div_valid_o(div_valid_o),
    .div_ready_i(div_ready_i),
    .cur_div_o  (cur_div_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .timeout_o  (timeout_o),
    .clr_err_i  (clr_err_i)
  );

  always #5 clk_i = ~clk_i;

  // Edge log: handshakes complete on this edge; done_o seen here was high in the cycle before.
  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (rst_ni && div_valid_o && div_ready_i) begin
      hs_val.push_back(int'(div_o));
      hs_cyc.push_back(cyc);
    end
    if (rst_ni && done_o) done_cyc.push_back(cyc);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step_cycles(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic clear_log();
    hs_val.delete();
    hs_cyc.delete();
    done_cyc.delete();
  endtask

  // Present one request for exactly one edge; returns in the cycle after acceptance.
  task automatic request(input logic [3:0] div, input logic [3:0] step, input logic [7:0] dwell);
    cfg_div_i   = div;
    cfg_step_i  = step;
    cfg_dwell_i = dwell;
    cfg_valid_i = 1'b1;
    step_cycles(1);
    cfg_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done_o && n < budget) begin
      step_cycles(1);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_o), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: DEFAULT_DIV_VALUE=0 normalises to 1
    step_cycles(2);
    check("rst_div", 32'(div_o), 32'd1);
    check("rst_cur", 32'(cur_div_o), 32'd1);
    check("rst_ready", 32'(cfg_ready_o), 32'd1);
    check("rst_valid", 32'(div_valid_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_timeout", 32'(timeout_o), 32'd0);
    rst_ni = 1'b1;
    step_cycles(2);

    // Same-value request: cfg 0 normalises to 1 == cur
    clear_log();
    request(4'd0, 4'd2, 8'd0);
    check("same_done", 32'(done_o), 32'd1);
    check("same_valid", 32'(div_valid_o), 32'd0);
    check("same_ready", 32'(cfg_ready_o), 32'd1);
    step_cycles(1);
    check("same_done_drop", 32'(done_o), 32'd0);
    step_cycles(3);
    check("same_no_hs", 32'(hs_val.size()), 32'd0);

    // Ramp up 1 -> 8, step 3, dwell 2: 4, 7, 8 spaced 4 cycles
    clear_log();
    div_ready_i = 1'b1;
    request(4'd8, 4'd3, 8'd2);
    check("up_valid_n1", 32'(div_valid_o), 32'd1);
    check("up_first_div", 32'(div_o), 32'd4);
    check("up_busy", 32'(busy_o), 32'd1);
    wait_done("up", 40);
    check("up_busy_in_done", 32'(busy_o), 32'd0);
    check("up_cur", 32'(cur_div_o), 32'd8);
    step_cycles(1);
    check("up_done_one_cycle", 32'(done_o), 32'd0);
    check("up_hs_count", 32'(hs_val.size()), 32'd3);
    if (hs_val.size() == 3 && done_cyc.size() == 1) begin
      check("up_hs0", 32'(hs_val[0]), 32'd4);
      check("up_hs1", 32'(hs_val[1]), 32'd7);
      check("up_hs2", 32'(hs_val[2]), 32'd8);
      check("up_gap01", 32'(hs_cyc[1] - hs_cyc[0]), 32'd4);
      check("up_gap12", 32'(hs_cyc[2] - hs_cyc[1]), 32'd4);
      check("up_done_after_hs", 32'(done_cyc[0] - hs_cyc[2]), 32'd1);
    end else begin
      check("up_done_count", 32'(done_cyc.size()), 32'd1);
    end

    // Ramp down 8 -> 2 with direct jump
    clear_log();
    request(4'd2, 4'd0, 8'd5);
    check("down_div", 32'(div_o), 32'd2);
    wait_done("down", 20);
    check("down_cur", 32'(cur_div_o), 32'd2);
    check("down_hs_count", 32'(hs_val.size()), 32'd1);
    if (hs_val.size() == 1) check("down_hs0", 32'(hs_val[0]), 32'd2);
    step_cycles(2);

    // Timeout: 2 -> 5 with ready held low for 70 ISSUE cycles
    clear_log();
    div_ready_i = 1'b0;
    request(4'd5, 4'd0, 8'd0);
    step_cycles(63);
    check("to_before_64", 32'(timeout_o), 32'd0);
    step_cycles(1);
    check("to_at_64", 32'(timeout_o), 32'd1);
    step_cycles(6);
    check("to_valid_held", 32'(div_valid_o), 32'd1);
    check("to_div_held", 32'(div_o), 32'd5);
    check("to_cur_unchanged", 32'(cur_div_o), 32'd2);
    div_ready_i = 1'b1;
    step_cycles(1);
    check("to_done", 32'(done_o), 32'd1);
    check("to_cur", 32'(cur_div_o), 32'd5);
    check("to_sticky", 32'(timeout_o), 32'd1);
    clr_err_i = 1'b1;
    step_cycles(1);
    clr_err_i = 1'b0;
    check("to_cleared", 32'(timeout_o), 32'd0);

    // Return to 1, then abort a 1 -> 8 ramp in its first DWELL
    request(4'd1, 4'd0, 8'd0);
    wait_done("back1", 20);
    step_cycles(1);
    clear_log();
    request(4'd8, 4'd3, 8'd2);
    step_cycles(1);
    check("ab_in_dwell", 32'(busy_o & ~div_valid_o), 32'd1);
    abort_i = 1'b1;
    step_cycles(1);
    abort_i = 1'b0;
    check("ab_idle", 32'(cfg_ready_o), 32'd1);
    check("ab_cur", 32'(cur_div_o), 32'd4);
    check("ab_no_done_now", 32'(done_o), 32'd0);
    step_cycles(8);
    check("ab_no_done", 32'(done_cyc.size()), 32'd0);
    check("ab_hs_count", 32'(hs_val.size()), 32'd1);

    // Asynchronous reset while a step is pending
    div_ready_i = 1'b0;
    request(4'd8, 4'd0, 8'd0);
    check("rr_valid_before", 32'(div_valid_o), 32'd1);
    #1 rst_ni = 1'b0;
    #1;
    check("rr_valid_drop", 32'(div_valid_o), 32'd0);
    check("rr_cur", 32'(cur_div_o), 32'd1);
    check("rr_div", 32'(div_o), 32'd1);
    check("rr_ready", 32'(cfg_ready_o), 32'd1);
    step_cycles(2);
    rst_ni = 1'b1;
    step_cycles(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
